// File: rtl/reaction_timer_unit.sv
// reaction_timer_unit: ms prescaler, saturating ms counter with random delay load, game countdown and LFSR
module reaction_timer_unit #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int MAX_MS       = 2047,
    parameter int GAME_SECONDS = 10,
    parameter int LED_NUM      = 18,
    parameter int MIN_DELAY_MS = 500
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            timer_reset,
    input  logic                            up,
    input  logic                            enable,
    input  logic                            game_reset,
    input  logic                            game_timer_enable,
    output logic [$clog2(MAX_MS)-1:0]       timer_value,
    output logic [$clog2(GAME_SECONDS)-1:0] game_timer_value,
    output logic [$clog2(LED_NUM)-1:0]      random_value,
    output logic                            ms_tick,
    output logic                            game_over
);
    localparam int PERIOD = CLK_HZ / 1000;
    localparam int PW = PERIOD > 1 ? $clog2(PERIOD) : 1;
    localparam int TW = $clog2(MAX_MS);
    localparam int GW = $clog2(GAME_SECONDS);
    localparam int RW = $clog2(LED_NUM);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] game_q, game_d;
    logic [9:0]    sub_q, sub_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [RW-1:0] rand_q, rand_d;
    logic [11:0]   delay_sum;

    assign delay_sum = 12'(MIN_DELAY_MS) + {2'b00, lfsr_q[9:0]};

    // prescaler restarts on a load so the next tick is a full ms away; LFSR and random index run every cycle
    always_comb begin
        presc_d = (timer_reset || presc_q == PW'(PERIOD - 1)) ? '0 : presc_q + 1'b1;
        tick_d  = !timer_reset && presc_q == PW'(PERIOD - 1);
        lfsr_d  = lfsr_q[0] ? (lfsr_q >> 1) ^ 16'hB400 : lfsr_q >> 1;
        rand_d  = RW'(lfsr_q % 16'(LED_NUM));
    end

    // ms counter: load has priority over a coinciding tick; counting saturates at both ends
    always_comb begin
        timer_d = timer_q;
        if (timer_reset)
            timer_d = up ? '0 : (delay_sum > 12'(MAX_MS) ? TW'(MAX_MS) : TW'(delay_sum));
        else if (enable && tick_q)
            timer_d = up ? (timer_q == TW'(MAX_MS) ? timer_q : timer_q + 1'b1)
                         : (timer_q == '0 ? timer_q : timer_q - 1'b1);
    end

    // game countdown: ms sub-counter wraps every 1000 ticks and then takes one second off, stopping at zero
    always_comb begin
        game_d = game_q;
        sub_d  = sub_q;
        if (game_reset) begin
            game_d = GW'(GAME_SECONDS);
            sub_d  = '0;
        end else if (game_timer_enable && tick_q) begin
            sub_d = sub_q == 10'd999 ? '0 : sub_q + 1'b1;
            if (sub_q == 10'd999 && game_q != '0)
                game_d = game_q - 1'b1;
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            timer_q <= '0;
            game_q  <= GW'(GAME_SECONDS);
            sub_q   <= '0;
            lfsr_q  <= 16'hACE1;
            rand_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            timer_q <= timer_d;
            game_q  <= game_d;
            sub_q   <= sub_d;
            lfsr_q  <= lfsr_d;
            rand_q  <= rand_d;
        end
    end

    assign timer_value      = timer_q;
    assign game_timer_value = game_q;
    assign random_value     = rand_q;
    assign ms_tick          = tick_q;
    assign game_over        = game_q == '0;
endmodule

// File: tb/tb_reaction_timer_unit.sv
// tb_reaction_timer_unit: randomized and directed checks against a behavioural model
module tb_reaction_timer_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        timer_reset = 1'b0, up = 1'b0, enable = 1'b0;
    logic        game_reset = 1'b0, game_timer_enable = 1'b0;
    logic [10:0] timer_value;
    logic [3:0]  game_timer_value;
    logic [4:0]  random_value;
    logic        ms_tick, game_over;

    int n_checks = 0, n_errors = 0;
    int m_timer, m_elapsed, m_cnt, m_rand;
    bit m_tick;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    reaction_timer_unit #(
        .CLK_HZ(4000), .MAX_MS(2047), .GAME_SECONDS(10), .LED_NUM(18), .MIN_DELAY_MS(500)
    ) dut (
        .clk(clk), .reset(reset), .timer_reset(timer_reset), .up(up), .enable(enable),
        .game_reset(game_reset), .game_timer_enable(game_timer_enable),
        .timer_value(timer_value), .game_timer_value(game_timer_value),
        .random_value(random_value), .ms_tick(ms_tick), .game_over(game_over)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_game();
        return m_elapsed >= 10000 ? 0 : 10 - m_elapsed / 1000;
    endfunction

    task automatic model_reset();
        m_timer = 0; m_elapsed = 0; m_cnt = 0; m_tick = 0; m_lfsr = 16'hACE1; m_rand = 0;
    endtask

    task automatic model_edge();
        bit tk = m_tick;
        logic [15:0] lf = m_lfsr;
        int d = 500 + int'(lf & 16'h03FF);
        if (timer_reset) m_timer = up ? 0 : (d > 2047 ? 2047 : d);
        else if (enable && tk) m_timer = up ? (m_timer < 2047 ? m_timer + 1 : 2047)
                                            : (m_timer > 0 ? m_timer - 1 : 0);
        if (game_reset) m_elapsed = 0;
        else if (game_timer_enable && tk && m_elapsed < 10000) m_elapsed++;
        m_rand = int'(lf % 18);
        m_lfsr = lf[0] ? (lf >> 1) ^ 16'hB400 : lf >> 1;
        m_cnt  = timer_reset ? 0 : m_cnt + 1;
        m_tick = m_cnt != 0 && m_cnt % 4 == 0;
    endtask

    task automatic check_all();
        check("timer", timer_value, m_timer);
        check("game", game_timer_value, m_game());
        check("over", game_over, m_game() == 0);
        check("random", random_value, m_rand);
        check("tick", ms_tick, m_tick);
        check("rand_range", random_value < 18, 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_final_tick(input bit rand_timer);
        for (int i = 0; i < 50000; i++) begin
            if (m_elapsed == 9999 && m_tick) break;
            if (rand_timer) begin
                timer_reset = $urandom_range(0, 63) == 0;
                up = 1'($urandom);
                enable = $urandom_range(0, 3) != 0;
            end
            step();
        end
        timer_reset = 1'b0;
        check("final_tick", {ms_tick, game_timer_value}, {1'b1, 4'd1});
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;
        check_all();
        timer_reset = 1'b1; up = 1'b0; game_timer_enable = 1'b1;
        step();
        check("delay_load", timer_value, 725);
        timer_reset = 1'b0; enable = 1'b1;
        run(600);
        game_timer_enable = 1'b0;
        run(2000);
        check("pause_hold", game_timer_value, 10);
        game_timer_enable = 1'b1;
        run(400);
        check("down_floor", timer_value, 0);
        run(40);
        check("down_hold", timer_value, 0);
        timer_reset = 1'b1; up = 1'b1;
        step();
        check("up_load", timer_value, 0);
        timer_reset = 1'b0;
        run(41);
        check("up_10", timer_value, 10);
        run(8200);
        check("up_ceiling", timer_value, 2047);
        run(40);
        check("up_hold", timer_value, 2047);
        enable = 1'b0;
        run_to_final_tick(1'b0);
        step();
        check("game_zero", game_timer_value, 0);
        check("game_over_hi", game_over, 1);
        run(400);
        check("game_stays_zero", game_timer_value, 0);
        game_reset = 1'b1;
        step();
        check("game_reload", game_timer_value, 10);
        check("game_over_lo", game_over, 0);
        game_reset = 1'b0;
        run_to_final_tick(1'b1);
        game_reset = 1'b1;
        step();
        check("reload_wins", game_timer_value, 10);
        check("reload_over", game_over, 0);
        for (int i = 0; i < 1500; i++) begin
            timer_reset = $urandom_range(0, 63) == 0;
            up = 1'($urandom);
            enable = $urandom_range(0, 3) != 0;
            game_reset = $urandom_range(0, 255) == 0;
            game_timer_enable = $urandom_range(0, 3) != 0;
            step();
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_game", game_timer_value, 10);
        @(negedge clk);
        check_all();
        reset = 1'b0; timer_reset = 1'b1; up = 1'b0; game_reset = 1'b0;
        step();
        check("delay_after_reset", timer_value, 725);
        check("lfsr_restart", random_value, 13);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
